// File: rtl/ddr_deserializer.sv
// ddr_deserializer
// Captures one sample on each clock edge, presents each posedge/negedge pair
// to a packing stage one posedge later, and packs valid samples (earliest in
// the least significant slot) into RATIO-sample words. A single output
// register holds completed words until the consumer takes them.
//
// Handshake: dout_valid_o means dout_o holds a complete word. The word is
// consumed at a posedge where dout_valid_o and dout_ready_i are both high.
// dout_o and dout_valid_o stay stable until then. A word that completes while
// the held word is not being consumed is dropped, and overflow_o latches
// until clear_i.
//
// WIDTH must be >= 1 and RATIO must lie in 2..8 (fill_o is 3 bits wide and at
// most one word can complete per posedge).
module ddr_deserializer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear_i,
    input  logic                     slip_i,
    input  logic                     din_valid_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic                     dout_valid_o,
    input  logic                     dout_ready_i,
    output logic [RATIO*WIDTH-1:0]   dout_o,
    output logic [2:0]               fill_o,
    output logic                     overflow_o
);

    // Edge capture registers (sample A on posedge, sample B on negedge).
    logic [WIDTH-1:0]       cap_a_q;
    logic                   cap_av_q;
    logic [WIDTH-1:0]       cap_b_q;
    logic                   cap_bv_q;

    // Pair stage: the pair captured in the previous cycle, packed this posedge.
    logic [WIDTH-1:0]       pair_a_q;
    logic                   pair_av_q;
    logic [WIDTH-1:0]       pair_b_q;
    logic                   pair_bv_q;

    // Packing and output state.
    logic [RATIO*WIDTH-1:0] acc_q, acc_d;
    logic [2:0]             fill_q, fill_d;
    logic                   slip_armed_q, slip_armed_d;
    logic [RATIO*WIDTH-1:0] dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   overflow_q, overflow_d;

    // Packing-stage intermediate signals.
    logic                   drop_a;
    logic                   drop_b;
    logic [1:0]             smp_v;
    logic [2*WIDTH-1:0]     smp;
    logic                   word_done;
    logic [RATIO*WIDTH-1:0] word;

    // Posedge capture of sample A with its own valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_a_q  <= '0;
            cap_av_q <= 1'b0;
        end else begin
            cap_a_q  <= din_i;
            cap_av_q <= din_valid_i;
        end
    end

    // Negedge capture of sample B with its own valid.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_b_q  <= '0;
            cap_bv_q <= 1'b0;
        end else begin
            cap_b_q  <= din_i;
            cap_bv_q <= din_valid_i;
        end
    end

    // Move the completed A/B pair into the posedge domain as one unit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pair_a_q  <= '0;
            pair_av_q <= 1'b0;
            pair_b_q  <= '0;
            pair_bv_q <= 1'b0;
        end else begin
            pair_a_q  <= cap_a_q;
            pair_av_q <= cap_av_q;
            pair_b_q  <= cap_b_q;
            pair_bv_q <= cap_bv_q;
        end
    end

    // An armed slip eats the first valid sample of the pair: A if valid, else B.
    assign drop_a = slip_armed_q & pair_av_q;
    assign drop_b = slip_armed_q & ~pair_av_q & pair_bv_q;
    assign smp_v  = {pair_bv_q & ~drop_b, pair_av_q & ~drop_a};
    assign smp    = {pair_b_q, pair_a_q};

    // Append up to two samples in order; a full accumulator emits a word and
    // any remaining sample starts the next word at slot 0.
    always_comb begin
        int fill_n;
        acc_d     = acc_q;
        fill_n    = int'(fill_q);
        word_done = 1'b0;
        word      = '0;
        for (int i = 0; i < 2; i++) begin
            if (smp_v[i]) begin
                acc_d[fill_n*WIDTH +: WIDTH] = smp[i*WIDTH +: WIDTH];
                fill_n = fill_n + 1;
                if (fill_n == RATIO) begin
                    word_done = 1'b1;
                    word      = acc_d;
                    acc_d     = '0;
                    fill_n    = 0;
                end
            end
        end
        fill_d = fill_n[2:0];
    end

    // Output register, overflow flag, slip arming and clear priority.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overflow_d   = overflow_q;
        slip_armed_d = (slip_armed_q & ~(drop_a | drop_b)) | slip_i;
        if (dout_valid_q && dout_ready_i) begin
            dout_valid_d = 1'b0;
        end
        if (word_done) begin
            if (!dout_valid_q || dout_ready_i) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                overflow_d   = 1'b1;
            end
        end
        if (clear_i) begin
            dout_valid_d = 1'b0;
            overflow_d   = 1'b0;
            slip_armed_d = 1'b0;
        end
    end

    // State registers; clear flushes partial words and discards this pair.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q        <= '0;
            fill_q       <= '0;
            slip_armed_q <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            acc_q        <= clear_i ? '0 : acc_d;
            fill_q       <= clear_i ? '0 : fill_d;
            slip_armed_q <= slip_armed_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign fill_o       = fill_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_ddr_deserializer.sv
// Directed bench for ddr_deserializer: a RATIO=4 instance and a RATIO=3
// instance share all inputs; each scenario checks the instance it targets.
module tb_ddr_deserializer;

    logic        clock;
    logic        reset_n;
    logic        clear_i;
    logic        slip_i;
    logic        din_valid_i;
    logic [7:0]  din_i;
    logic        dout_ready_i;

    logic        d4_valid;
    logic [31:0] d4_dout;
    logic [2:0]  d4_fill;
    logic        d4_ovf;
    logic        d3_valid;
    logic [23:0] d3_dout;
    logic [2:0]  d3_fill;
    logic        d3_ovf;

    int n_cmp;
    int n_err;

    ddr_deserializer #(.WIDTH(8), .RATIO(4)) u_d4 (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_i      (clear_i),
        .slip_i       (slip_i),
        .din_valid_i  (din_valid_i),
        .din_i        (din_i),
        .dout_valid_o (d4_valid),
        .dout_ready_i (dout_ready_i),
        .dout_o       (d4_dout),
        .fill_o       (d4_fill),
        .overflow_o   (d4_ovf)
    );

    ddr_deserializer #(.WIDTH(8), .RATIO(3)) u_d3 (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_i      (clear_i),
        .slip_i       (slip_i),
        .din_valid_i  (din_valid_i),
        .din_i        (din_i),
        .dout_valid_o (d3_valid),
        .dout_ready_i (dout_ready_i),
        .dout_o       (d3_dout),
        .fill_o       (d3_fill),
        .overflow_o   (d3_ovf)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: A is driven for the coming posedge, B for the
    // following negedge. Returns 1ns after that posedge.
    task automatic cyc(input logic av, input logic [7:0] a, input logic bv, input logic [7:0] b);
        @(negedge clock);
        #1;
        din_valid_i = av;
        din_i       = a;
        @(posedge clock);
        #1;
        din_valid_i = bv;
        din_i       = b;
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        idle();
        clear_i = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset_n      = 1'b0;
        clear_i      = 1'b0;
        slip_i       = 1'b0;
        din_valid_i  = 1'b1;
        din_i        = 8'h5A;
        dout_ready_i = 1'b1;

        // Reset state, with clocks running and valid data on din
        #17;
        check_eq("rst_d4_valid", {31'd0, d4_valid}, 32'd0);
        check_eq("rst_d4_dout",  d4_dout, 32'd0);
        check_eq("rst_d4_fill",  {29'd0, d4_fill}, 32'd0);
        check_eq("rst_d4_ovf",   {31'd0, d4_ovf}, 32'd0);
        check_eq("rst_d3_valid", {31'd0, d3_valid}, 32'd0);
        check_eq("rst_d3_fill",  {29'd0, d3_fill}, 32'd0);
        din_valid_i = 1'b0;
        #5;
        reset_n = 1'b1;
        idle();
        idle();
        check_eq("post_rst_fill", {29'd0, d4_fill}, 32'd0);

        // All samples valid: 01,02 then 03,04
        cyc(1'b1, 8'h01, 1'b1, 8'h02);
        cyc(1'b1, 8'h03, 1'b1, 8'h04);
        idle();
        check_eq("full_fill_mid",  {29'd0, d4_fill}, 32'd2);
        check_eq("full_lat_early", {31'd0, d4_valid}, 32'd0);
        idle();
        check_eq("full_valid", {31'd0, d4_valid}, 32'd1);
        check_eq("full_dout",  d4_dout, 32'h04030201);
        check_eq("full_fill",  {29'd0, d4_fill}, 32'd0);
        idle();
        check_eq("full_accept", {31'd0, d4_valid}, 32'd0);
        pulse_clear();

        // Rising-edge samples only; falling data must be ignored
        cyc(1'b1, 8'h11, 1'b0, 8'hEE);
        cyc(1'b1, 8'h22, 1'b0, 8'hEE);
        cyc(1'b1, 8'h33, 1'b0, 8'hEE);
        cyc(1'b1, 8'h44, 1'b0, 8'hEE);
        idle();
        idle();
        check_eq("rise_valid", {31'd0, d4_valid}, 32'd1);
        check_eq("rise_dout",  d4_dout, 32'h44332211);
        idle();

        // Two slip pulses arm only one drop; consumer holds off
        dout_ready_i = 1'b0;
        slip_i = 1'b1;
        idle();
        idle();
        slip_i = 1'b0;
        cyc(1'b1, 8'h01, 1'b1, 8'h02);
        cyc(1'b1, 8'h03, 1'b1, 8'h04);
        cyc(1'b1, 8'h05, 1'b1, 8'h06);
        cyc(1'b1, 8'h07, 1'b1, 8'h08);
        idle();
        idle();
        check_eq("slip_valid", {31'd0, d4_valid}, 32'd1);
        check_eq("slip_dout",  d4_dout, 32'h05040302);
        check_eq("slip_fill",  {29'd0, d4_fill}, 32'd3);
        pulse_clear();
        check_eq("slip_clr_valid", {31'd0, d4_valid}, 32'd0);
        check_eq("slip_clr_fill",  {29'd0, d4_fill}, 32'd0);

        // Overflow: eight samples with the consumer stalled
        cyc(1'b1, 8'h11, 1'b1, 8'h12);
        cyc(1'b1, 8'h13, 1'b1, 8'h14);
        cyc(1'b1, 8'h15, 1'b1, 8'h16);
        cyc(1'b1, 8'h17, 1'b1, 8'h18);
        idle();
        idle();
        check_eq("ovf_valid", {31'd0, d4_valid}, 32'd1);
        check_eq("ovf_dout",  d4_dout, 32'h14131211);
        check_eq("ovf_flag",  {31'd0, d4_ovf}, 32'd1);
        check_eq("ovf_fill",  {29'd0, d4_fill}, 32'd0);
        pulse_clear();
        check_eq("ovf_clr_flag",  {31'd0, d4_ovf}, 32'd0);
        check_eq("ovf_clr_valid", {31'd0, d4_valid}, 32'd0);

        // RATIO=3: back-to-back words with no bubble
        dout_ready_i = 1'b1;
        pulse_clear();
        cyc(1'b1, 8'h01, 1'b1, 8'h02);
        cyc(1'b1, 8'h03, 1'b1, 8'h04);
        cyc(1'b1, 8'h05, 1'b1, 8'h06);
        idle();
        check_eq("r3_w1_valid", {31'd0, d3_valid}, 32'd1);
        check_eq("r3_w1_dout",  {8'd0, d3_dout}, 32'h00030201);
        check_eq("r3_w1_fill",  {29'd0, d3_fill}, 32'd1);
        idle();
        check_eq("r3_w2_valid", {31'd0, d3_valid}, 32'd1);
        check_eq("r3_w2_dout",  {8'd0, d3_dout}, 32'h00060504);
        idle();
        check_eq("r3_drain", {31'd0, d3_valid}, 32'd0);

        // Reset mid-word discards the partial accumulation
        pulse_clear();
        cyc(1'b1, 8'hB1, 1'b1, 8'hB2);
        idle();
        idle();
        check_eq("mid_fill", {29'd0, d4_fill}, 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_fill",  {29'd0, d4_fill}, 32'd0);
        check_eq("mid_rst_dout",  d4_dout, 32'd0);
        check_eq("mid_rst_valid", {31'd0, d4_valid}, 32'd0);
        check_eq("mid_rst_ovf",   {31'd0, d4_ovf}, 32'd0);
        #15;
        reset_n = 1'b1;
        cyc(1'b1, 8'hA1, 1'b1, 8'hA2);
        cyc(1'b1, 8'hA3, 1'b1, 8'hA4);
        idle();
        idle();
        check_eq("after_rst_valid", {31'd0, d4_valid}, 32'd1);
        check_eq("after_rst_dout",  d4_dout, 32'hA4A3A2A1);
        check_eq("after_rst_fill",  {29'd0, d4_fill}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_deserializer.md
DDR_DESERIALIZER -- requirements
Module: ddr_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, bits per DDR sample; SHALL be at least 1.
REQ-002 Parameter RATIO, default 4, samples packed per output word; SHALL be in the range 2..8.
REQ-003 clock  input  1  sample clock; din is captured on both edges.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous flush of all partial state, sampled on posedge.
REQ-006 slip  input  1  one-cycle pulse; drops the next valid sample to realign words.
REQ-007 din_valid  input  1  qualifies din on each clock edge independently.
REQ-008 din  input  WIDTH  DDR data sample.
REQ-009 dout_valid  output  1  dout holds a complete word.
REQ-010 dout_ready  input  1  consumer accepts dout when dout_valid and dout_ready are both high at a posedge.
REQ-011 dout  output  RATIO*WIDTH  packed word; the earliest sample occupies bits [WIDTH-1:0].
REQ-012 fill  output  3  number of samples currently held in the accumulator (0..RATIO-1).
REQ-013 overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-014 Capture: the posedge sample (A) and the following negedge sample (B) of clock cycle k SHALL each be registered with their own din_valid.
REQ-015 The registered pair SHALL be presented together to the packing stage at posedge k+1.
REQ-016 Ordering: A SHALL precede B; invalid samples SHALL be skipped and SHALL NOT occupy a slot.
REQ-017 Packing: each posedge SHALL append 0, 1 or 2 valid samples to the accumulator, in order.
REQ-018 When the accumulator reaches RATIO samples, a word SHALL complete.
REQ-019 Any sample left over after a completed word (RATIO odd, or fill=RATIO-1 with 2 new samples) SHALL become slot 0 of the next word.
REQ-020 Latency: a word whose last sample was captured in cycle k SHALL assert dout_valid from posedge k+2.
REQ-021 Output holding: dout and dout_valid SHALL remain stable until the word is accepted.
REQ-022 On acceptance with no new word completing, dout_valid SHALL deassert at that posedge.
REQ-023 On acceptance in the same cycle a new word completes, the new word SHALL load, dout_valid SHALL stay high, and no bubble SHALL occur.
REQ-024 Overflow: if a word completes while dout_valid=1 and dout_ready=0, the new word SHALL be discarded and overflow SHALL set.
REQ-025 In the overflow case the held dout SHALL be kept and fill SHALL still advance normally.
REQ-026 Slip: a slip pulse SHALL arm a one-shot drop.
REQ-027 The first valid sample to reach the packing stage after slip is armed SHALL be discarded, and the drop SHALL then disarm.
REQ-028 Slip pulses received while a drop is already armed SHALL NOT accumulate.
REQ-029 If both samples of a pair are valid when the drop applies, only A SHALL be dropped and B SHALL be packed.
REQ-030 Clear SHALL zero fill, disarm slip, discard the pair in the packing stage and deassert dout_valid.
REQ-031 Clear SHALL reset overflow to 0.
REQ-032 Clear SHALL take priority over packing, slip and acceptance in the same cycle.
REQ-033 fill SHALL update at the same posedge as the packing it reflects.

Reset
REQ-034 While reset_n=0, all registers SHALL clear asynchronously, including both edge-capture stages.
REQ-035 In reset, dout_valid=0, dout=0, fill=0, overflow=0 and slip disarmed.
REQ-036 Reset asserted mid-word SHALL discard the partial accumulation; no stale sample SHALL appear after release.
REQ-037 The first capture after release SHALL be the first posedge (or negedge) following reset_n going high.

Verification (WIDTH=8, RATIO=4)
REQ-038 Two cycles with all samples valid: 01,02 then 03,04 -> dout=0x04030201, dout_valid asserted 2 cycles after the cycle carrying 04, fill=0.
REQ-039 Only rising samples valid (falling din_valid=0): 11,22,33,44 over 4 cycles -> dout=0x44332211; the falling-edge data is ignored.
REQ-040 slip pulse, then stream 01..08 all valid -> first word=0x05040302, fill=3 holding 06,07,08.
REQ-041 dout_ready=0 while 8 samples arrive -> first word held, second dropped, overflow=1; after a clear pulse, overflow=0 and dout_valid=0.
REQ-042 RATIO=3 stream 01..06 all valid -> words 0x030201 then 0x060504, back-to-back with dout_ready=1 and no bubble.
REQ-043 reset_n pulsed low with fill=2 -> outputs clear immediately; next 4 valid samples A1..A4 -> dout=0xA4A3A2A1.
